// File: rtl/pulse_train_generator.sv
// Pulse-train generator: latches high/low lengths and a pulse count on start, then plays
// count*(high+low) cycles of registered output. Optional o_edge strobe: PULSE_TRAIN_EDGE_MARK_EN.
module pulse_train_generator #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [CNT_W-1:0] i_high_len,
   input  logic [CNT_W-1:0] i_low_len,
   input  logic [CNT_W-1:0] i_count,
   input  logic             i_abort,
   output logic             o_pulse,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_edge
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t           state, state_nxt;
   // Phase lengths are held as (len-1) so a zero length naturally behaves as one cycle.
   logic [CNT_W-1:0] high_m1, high_m1_nxt;
   logic [CNT_W-1:0] low_m1, low_m1_nxt;
   logic [CNT_W-1:0] remaining, remaining_nxt;
   logic [CNT_W-1:0] phase, phase_nxt;
   logic             pulse_nxt, busy_nxt, done_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         high_m1   <= '0;
         low_m1    <= '0;
         remaining <= '0;
         phase     <= '0;
         o_pulse   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         state     <= state_nxt;
         high_m1   <= high_m1_nxt;
         low_m1    <= low_m1_nxt;
         remaining <= remaining_nxt;
         phase     <= phase_nxt;
         o_pulse   <= pulse_nxt;
         o_busy    <= busy_nxt;
         o_done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      high_m1_nxt   = high_m1;
      low_m1_nxt    = low_m1;
      remaining_nxt = remaining;
      phase_nxt     = phase;
      pulse_nxt     = o_pulse;
      busy_nxt      = o_busy;
      done_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (i_start && !i_abort) begin
               if (i_count == '0) begin
                  done_nxt = 1'b1;
               end else begin
                  high_m1_nxt   = (i_high_len == '0) ? '0 : i_high_len - 1'b1;
                  low_m1_nxt    = (i_low_len == '0) ? '0 : i_low_len - 1'b1;
                  remaining_nxt = i_count;
                  phase_nxt     = (i_high_len == '0) ? '0 : i_high_len - 1'b1;
                  state_nxt     = HIGH;
                  pulse_nxt     = 1'b1;
                  busy_nxt      = 1'b1;
               end
            end
         end
         HIGH: begin
            if (i_abort) begin
               state_nxt = IDLE;
               pulse_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end else if (phase == '0) begin
               state_nxt = LOW;
               pulse_nxt = 1'b0;
               phase_nxt = low_m1;
            end else begin
               phase_nxt = phase - 1'b1;
            end
         end
         LOW: begin
            if (i_abort) begin
               state_nxt = IDLE;
               pulse_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end else if (phase == '0) begin
               if (remaining == 1) begin
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  remaining_nxt = remaining - 1'b1;
                  state_nxt     = HIGH;
                  pulse_nxt     = 1'b1;
                  phase_nxt     = high_m1;
               end
            end else begin
               phase_nxt = phase - 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            pulse_nxt = 1'b0;
            busy_nxt  = 1'b0;
         end
      endcase
   end

`ifdef PULSE_TRAIN_EDGE_MARK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) o_edge <= 1'b0;
      else        o_edge <= (pulse_nxt != o_pulse);
   end
`else
   assign o_edge = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_train_generator.sv
// Bench for pulse_train_generator: constant vector table, hand-written corner sequences,
// and random traffic checked against a queue-based reference of the expected waveform.
module tb_pulse_train_generator;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_start = 1'b0, i_abort = 1'b0;
   logic [W-1:0] i_high_len = '0, i_low_len = '0, i_count = '0;
   logic         o_pulse, o_busy, o_done, o_edge;

   pulse_train_generator #(.CNT_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_high_len(i_high_len),
      .i_low_len(i_low_len), .i_count(i_count), .i_abort(i_abort),
      .o_pulse(o_pulse), .o_busy(o_busy), .o_done(o_done), .o_edge(o_edge));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference: the remaining waveform of the running train, head = value currently shown.
   bit q[$];
   bit prev_p = 1'b0;
   bit e_p = 1'b0, e_b = 1'b0, e_d = 1'b0, e_e = 1'b0;

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge();
      bit np, nb, nd;
      int h, l;
      np = 0; nb = 0; nd = 0;
      if (!rst_n) begin
         q.delete();
      end else if (q.size() > 0) begin
         if (i_abort) q.delete();
         else begin
            void'(q.pop_front());
            if (q.size() > 0) begin np = q[0]; nb = 1; end
            else nd = 1;
         end
      end else if (i_start && !i_abort) begin
         if (i_count == 0) nd = 1;
         else begin
            h = (i_high_len == 0) ? 1 : int'(i_high_len);
            l = (i_low_len == 0) ? 1 : int'(i_low_len);
            for (int c = 0; c < int'(i_count); c++) begin
               for (int k = 0; k < h; k++) q.push_back(1'b1);
               for (int k = 0; k < l; k++) q.push_back(1'b0);
            end
            np = 1; nb = 1;
         end
      end
`ifdef PULSE_TRAIN_EDGE_MARK_EN
      e_e = rst_n && (np != prev_p);
`else
      e_e = 0;
`endif
      prev_p = np;
      e_p = np; e_b = nb; e_d = nd;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare 1 time unit later.
   task automatic step(input bit s, input bit a, input bit r,
                       input logic [W-1:0] h, input logic [W-1:0] l, input logic [W-1:0] c);
      i_start = s; i_abort = a; rst_n = r;
      i_high_len = h; i_low_len = l; i_count = c;
      @(posedge clk);
      model_edge();
      #1;
      chk("model_pulse", o_pulse, e_p);
      chk("model_busy", o_busy, e_b);
      chk("model_done", o_done, e_d);
      chk("model_edge", o_edge, e_e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 8'd9, 8'd9, 8'd9);
   endtask

   typedef struct {
      bit s, a;
      logic [W-1:0] h, l, c;
      bit p, b, d;
   } vec_t;

   vec_t vt[$];
   int   busy_cnt;

   initial begin
      // single pulse 3/2/1
      vt.push_back('{1,0,3,2,1, 1,1,0});
      vt.push_back('{0,0,0,0,0, 1,1,0});
      vt.push_back('{0,0,0,0,0, 1,1,0});
      vt.push_back('{0,0,0,0,0, 0,1,0});
      vt.push_back('{0,0,0,0,0, 0,1,0});
      vt.push_back('{0,0,0,0,0, 0,0,1});
      vt.push_back('{0,0,0,0,0, 0,0,0});
      // count = 0
      vt.push_back('{1,0,4,4,0, 0,0,1});
      vt.push_back('{0,0,0,0,0, 0,0,0});
      // start with abort in IDLE
      vt.push_back('{1,1,2,2,2, 0,0,0});
      vt.push_back('{0,0,0,0,0, 0,0,0});
      // zero lengths, count 2
      vt.push_back('{1,0,0,0,2, 1,1,0});
      vt.push_back('{0,0,0,0,0, 0,1,0});
      vt.push_back('{0,0,0,0,0, 1,1,0});
      vt.push_back('{0,0,0,0,0, 0,1,0});
      vt.push_back('{0,0,0,0,0, 0,0,1});
      // restart accepted while o_done is high
      vt.push_back('{1,0,1,1,1, 1,1,0});
      vt.push_back('{0,0,0,0,0, 0,1,0});
      vt.push_back('{0,0,0,0,0, 0,0,1});
      vt.push_back('{1,0,1,1,1, 1,1,0});
      vt.push_back('{0,0,0,0,0, 0,1,0});
      vt.push_back('{0,0,0,0,0, 0,0,1});
      vt.push_back('{0,0,0,0,0, 0,0,0});

      // reset state
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("reset_pulse", o_pulse, 1'b0);
      chk("reset_busy", o_busy, 1'b0);
      chk("reset_done", o_done, 1'b0);
      chk("reset_edge", o_edge, 1'b0);
      idle(2);

      foreach (vt[i]) begin
         step(vt[i].s, vt[i].a, 1, vt[i].h, vt[i].l, vt[i].c);
         chk($sformatf("vec%0d_pulse", i), o_pulse, vt[i].p);
         chk($sformatf("vec%0d_busy", i), o_busy, vt[i].b);
         chk($sformatf("vec%0d_done", i), o_done, vt[i].d);
      end

      // train 1/1/4, then abort of a 5/x/3 train at edge 3
      step(1, 0, 1, 1, 1, 4);
      idle(10);
      step(1, 0, 1, 5, 2, 3);
      idle(2);
      step(0, 1, 1, 0, 0, 0);
      chk("abort_pulse", o_pulse, 1'b0);
      chk("abort_busy", o_busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("abort_no_done", o_done, 1'b0);
      end
      step(1, 0, 1, 2, 1, 2);
      idle(8);

      // start mid-train with other fields is ignored: 2/2/1 stays 4 busy cycles
      step(1, 0, 1, 2, 2, 1);
      step(0, 0, 1, 0, 0, 0);
      step(1, 0, 1, 7, 7, 7);
      step(0, 0, 1, 0, 0, 0);
      chk("ign_busy_last", o_busy, 1'b1);
      step(0, 0, 1, 0, 0, 0);
      chk("ign_done", o_done, 1'b1);
      chk("ign_busy_end", o_busy, 1'b0);
      idle(2);

      // reset mid-train, then a normal train
      step(1, 0, 1, 2, 1, 2);
      idle(3);
      step(0, 0, 0, 0, 0, 0);
      chk("rst_mid_pulse", o_pulse, 1'b0);
      chk("rst_mid_busy", o_busy, 1'b0);
      chk("rst_mid_edge", o_edge, 1'b0);
      step(0, 0, 1, 0, 0, 0);
      chk("rst_mid_no_done", o_done, 1'b0);
      step(1, 0, 1, 2, 1, 2);
      idle(8);

      // maximum lengths: busy exactly 510 cycles
      busy_cnt = 0;
      step(1, 0, 1, 8'd255, 8'd255, 8'd1);
      for (int i = 0; i < 600; i++) begin
         if (o_busy) busy_cnt++;
         step(0, 0, 1, 0, 0, 0);
      end
      checks++;
      if (busy_cnt != 510) begin
         errors++;
         $display("FAIL max_len_busy: got %0d cycles expected 510", busy_cnt);
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
              $urandom_range(0, 199) != 0,
              W'($urandom_range(0, 4)), W'($urandom_range(0, 4)), W'($urandom_range(0, 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
